// File: rtl/button_cmd_gen.sv
// button_cmd_gen: turns three raw, bouncy push buttons (clear, up, down)
// into clean one-hot single-cycle command pulses for the level FSM.
// It also auto-repeats up/down while they are held.
// Pipeline per bit: 2-flop synchronizer -> debounce -> rising-edge detect.
// Up/down each have a repeat FSM. One arbiter picks the single pulse to emit.
module button_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_btnRaw,
  output logic [2:0] o_button,
  output logic [2:0] o_btnLevel
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  // The timer only ever holds load values up to TMAX-1.
  localparam int TW   = $clog2(TMAX);

  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_e;

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    level_q;
  logic [2:0]    press;
  logic [2:0]    evt;
  logic [2:1]    rep_evt;
  logic [CW-1:0] db_cnt [3];

  // Two-flop synchronizer for the asynchronous raw buttons.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_btnRaw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_debounce
    // Count consecutive cycles that disagree with the stable level.
    // Toggle the level once the count reaches DEBOUNCE_CYCLES.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        db_cnt[g] <= '0;
        level[g]  <= 1'b0;
      end else if (db_cnt[g] == DB_LAST) begin
        db_cnt[g] <= '0;
        level[g]  <= ~level[g];
      end else if (sync2[g] != level[g]) begin
        db_cnt[g] <= db_cnt[g] + 1'b1;
      end else begin
        db_cnt[g] <= '0;
      end
    end
  end

  // Registered copy of the stable level, used to find rising edges.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      level_q <= '0;
    end else begin
      level_q <= level;
    end
  end

  assign press      = level & ~level_q;
  assign o_btnLevel = level;

  for (genvar g = 1; g < 3; g++) begin : g_repeat
    rep_state_e    state;
    logic [TW-1:0] timer;
    logic          abort;

    // Leave repeat mode on release, on the opposite direction, or on clear.
    assign abort      = !level[g] || level[3-g] || level[0];
    assign rep_evt[g] = (state != IDLE) && (timer == '0) && !abort;

    // Repeat FSM. It arms only on a press pulse that actually won arbitration.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        state <= IDLE;
        timer <= '0;
      end else if ((REPEAT_EN == 0) || abort) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (evt[g]) begin
              state <= DELAY;
              timer <= DELAY_LOAD;
            end
          end
          DELAY: begin
            if (timer == '0) begin
              state <= REPEAT;
              timer <= PERIOD_LOAD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          REPEAT: begin
            if (timer == '0) begin
              timer <= PERIOD_LOAD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

  // Fixed-priority arbitration: clear > up > down.
  // Losing events are dropped, and an active clear level mutes up and down.
  always_comb begin
    evt = '0;
    if (press[0]) begin
      evt = 3'b001;
    end else if (!level[0]) begin
      if (press[1] || rep_evt[1]) begin
        evt = 3'b010;
      end else if (press[2] || rep_evt[2]) begin
        evt = 3'b100;
      end
    end
  end

  // Registered command output.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_button <= '0;
    end else begin
      o_button <= evt;
    end
  end

endmodule

// File: tb/tb_button_cmd_gen.sv
// Directed testbench for button_cmd_gen, built with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20 and REPEAT_PERIOD=8.
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
// "Edge c" is the c-th rising edge after the first edge that samples a new input.
module tb_button_cmd_gen;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [2:0] i_btnRaw;
  logic [2:0] o_button;
  logic [2:0] o_btnLevel;

  int n_checks = 0;
  int n_fail   = 0;

  button_cmd_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .REPEAT_EN      (1)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_btnRaw  (i_btnRaw),
    .o_button  (o_button),
    .o_btnLevel(o_btnLevel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    i_reset  = 1'b1;
    i_btnRaw = 3'b000;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset  = 1'b1;
    i_btnRaw = 3'b000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_button !== 3'b000 || o_btnLevel !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d: button=%b level=%b, expected 000/000", c, o_button, o_btnLevel);
      end
    end
    i_reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_button !== 3'b000 || o_btnLevel !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: button=%b level=%b, expected 000/000", c, o_button, o_btnLevel);
      end
    end
  endtask

  task automatic test_single_press();
    logic [2:0] exp_btn;
    logic [2:0] exp_lvl;
    do_reset();
    i_btnRaw = 3'b010;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      exp_lvl = (c >= 6 && c < 16) ? 3'b010 : 3'b000;
      exp_btn = (c == 7) ? 3'b010 : 3'b000;
      n_checks++;
      if (o_btnLevel !== exp_lvl) begin
        n_fail++;
        $display("FAIL single_level c=%0d: level=%b expected %b", c, o_btnLevel, exp_lvl);
      end
      n_checks++;
      if (o_button !== exp_btn) begin
        n_fail++;
        $display("FAIL single_pulse c=%0d: button=%b expected %b", c, o_button, exp_btn);
      end
      if (c == 9) i_btnRaw = 3'b000;
    end
  endtask

  task automatic test_glitch_repeat();
    logic [2:0] exp_btn;
    logic [2:0] exp_lvl;
    do_reset();
    i_btnRaw = 3'b100;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_btnLevel !== 3'b000 || o_button !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch c=%0d: button=%b level=%b expected 000/000", c, o_button, o_btnLevel);
      end
      if (c == 2) i_btnRaw = 3'b000;
    end
    i_btnRaw = 3'b100;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      exp_lvl = (c >= 6 && c < 66) ? 3'b100 : 3'b000;
      exp_btn = ((c == 7) || (c >= 27 && c < 66 && ((c - 27) % 8) == 0)) ? 3'b100 : 3'b000;
      n_checks++;
      if (o_btnLevel !== exp_lvl) begin
        n_fail++;
        $display("FAIL repeat_level c=%0d: level=%b expected %b", c, o_btnLevel, exp_lvl);
      end
      n_checks++;
      if (o_button !== exp_btn) begin
        n_fail++;
        $display("FAIL repeat_pulse c=%0d: button=%b expected %b", c, o_button, exp_btn);
      end
      if (c == 59) i_btnRaw = 3'b000;
    end
  endtask

  task automatic test_up_down();
    logic [2:0] exp_btn;
    logic [2:0] exp_lvl;
    do_reset();
    i_btnRaw = 3'b110;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      exp_lvl = (c >= 6 && c < 66) ? 3'b110 : 3'b000;
      exp_btn = (c == 7) ? 3'b010 : 3'b000;
      n_checks++;
      if (o_btnLevel !== exp_lvl) begin
        n_fail++;
        $display("FAIL updown_level c=%0d: level=%b expected %b", c, o_btnLevel, exp_lvl);
      end
      n_checks++;
      if (o_button !== exp_btn) begin
        n_fail++;
        $display("FAIL updown_pulse c=%0d: button=%b expected %b", c, o_button, exp_btn);
      end
      if (c == 59) i_btnRaw = 3'b000;
    end
  endtask

  task automatic test_clear_dominance();
    logic [2:0] exp_btn;
    logic [2:0] exp_lvl;
    do_reset();
    i_btnRaw = 3'b001;
    for (int c = 0; c < 66; c++) begin
      @(negedge clk);
      exp_lvl = {1'b0, (c >= 16 && c < 56), (c >= 6 && c < 36)};
      exp_btn = (c == 7) ? 3'b001 : 3'b000;
      n_checks++;
      if (o_btnLevel !== exp_lvl) begin
        n_fail++;
        $display("FAIL clear_level c=%0d: level=%b expected %b", c, o_btnLevel, exp_lvl);
      end
      n_checks++;
      if (o_button !== exp_btn) begin
        n_fail++;
        $display("FAIL clear_pulse c=%0d: button=%b expected %b", c, o_button, exp_btn);
      end
      if (c == 9)  i_btnRaw = 3'b011;
      if (c == 29) i_btnRaw = 3'b010;
      if (c == 49) i_btnRaw = 3'b000;
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [2:0] exp_btn;
    logic [2:0] exp_lvl;
    do_reset();
    i_btnRaw = 3'b010;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      exp_lvl = (c >= 6) ? 3'b010 : 3'b000;
      exp_btn = (c == 7 || c == 27 || c == 35) ? 3'b010 : 3'b000;
      n_checks++;
      if (o_btnLevel !== exp_lvl || o_button !== exp_btn) begin
        n_fail++;
        $display("FAIL midhold_pre c=%0d: button=%b level=%b expected %b/%b",
                 c, o_button, o_btnLevel, exp_btn, exp_lvl);
      end
    end
    i_reset = 1'b1;
    #1;
    n_checks++;
    if (o_button !== 3'b000 || o_btnLevel !== 3'b000) begin
      n_fail++;
      $display("FAIL midhold_async: button=%b level=%b expected 000/000", o_button, o_btnLevel);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_button !== 3'b000 || o_btnLevel !== 3'b000) begin
      n_fail++;
      $display("FAIL midhold_inreset: button=%b level=%b expected 000/000", o_button, o_btnLevel);
    end
    i_reset = 1'b0;
    for (int c = 0; c < 61; c++) begin
      @(negedge clk);
      exp_lvl = (c >= 6) ? 3'b010 : 3'b000;
      exp_btn = ((c == 7) || (c >= 27 && ((c - 27) % 8) == 0)) ? 3'b010 : 3'b000;
      n_checks++;
      if (o_btnLevel !== exp_lvl) begin
        n_fail++;
        $display("FAIL midhold_level c=%0d: level=%b expected %b", c, o_btnLevel, exp_lvl);
      end
      n_checks++;
      if (o_button !== exp_btn) begin
        n_fail++;
        $display("FAIL midhold_pulse c=%0d: button=%b expected %b", c, o_button, exp_btn);
      end
    end
    i_btnRaw = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch_repeat();
    test_up_down();
    test_clear_dominance();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
